// File: rtl/mont_mod_exp_conv_out.sv
// Montgomery exponentiation output stage: converts result_mont out of Montgomery
// form (x * R^-1 mod n, R = 2^NBITS) by bit-serial REDC plus one conditional subtract.
module mont_mod_exp_conv_out #(
  parameter int unsigned NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*NBITS-1:0] istream_msg,
  input  logic               istream_val,
  output logic               istream_rdy,
  output logic [NBITS-1:0]   ostream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy
);

  localparam int unsigned CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned TW = NBITS + 1;
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_next;
  logic [NBITS:0]  t, t_next;
  logic [NBITS-1:0] n_reg, n_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [NBITS:0]  n_ext;

  assign n_ext = {1'b0, n_reg};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      t     <= '0;
      n_reg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      t     <= t_next;
      n_reg <= n_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    t_next     = t;
    n_next     = n_reg;
    case (state)
      IDLE: begin
        if (istream_val) begin
          t_next     = {1'b0, istream_msg[NBITS-1:0]};
          n_next     = istream_msg[2*NBITS-1:NBITS];
          cnt_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        // Sum is widened by one bit so the adder carry survives the shift.
        if (t[0])
          t_next = TW'(({1'b0, t} + {2'b00, n_reg}) >> 1);
        else
          t_next = t >> 1;
        if (cnt == LAST) begin
          cnt_next   = '0;
          state_next = FIX;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      FIX: begin
        if (t >= n_ext)
          t_next = t - n_ext;
        state_next = DONE;
      end
      DONE: begin
        if (ostream_rdy)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign istream_rdy = (state == IDLE);
  assign ostream_val = (state == DONE);
  assign ostream_msg = t[NBITS-1:0];

endmodule

// File: tb/tb_mont_mod_exp_conv_out.sv
// Scoreboard bench for mont_mod_exp_conv_out: expected results queued at input
// acceptance, popped and compared at each output transfer.
module tb_mont_mod_exp_conv_out;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] istream_msg;
  logic        istream_val;
  logic        istream_rdy;
  logic [31:0] ostream_msg;
  logic        ostream_val;
  logic        ostream_rdy;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned rx_count = 0;
  int unsigned accept_rx = 0;
  logic [31:0] sb[$];

  mont_mod_exp_conv_out #(.NBITS(32)) dut (
    .clk(clk),
    .reset(reset),
    .istream_msg(istream_msg),
    .istream_val(istream_val),
    .istream_rdy(istream_rdy),
    .ostream_msg(ostream_msg),
    .ostream_val(ostream_val),
    .ostream_rdy(ostream_rdy)
  );

  always #5 clk = ~clk;

  // x * R^-1 mod n via repeated multiplication by the inverse of 2 (n odd)
  function automatic logic [31:0] model(input logic [31:0] n, input logic [31:0] x);
    logic [63:0] r;
    logic [63:0] inv2;
    r    = {32'd0, x} % {32'd0, n};
    inv2 = ({32'd0, n} + 64'd1) >> 1;
    for (int i = 0; i < 32; i++) r = (r * inv2) % {32'd0, n};
    return r[31:0];
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && ostream_val === 1'b1 && ostream_rdy === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_output got=%0d expected=none", ostream_msg);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (ostream_msg !== e) begin
          failures++;
          $display("FAIL sb_result got=%0d expected=%0d", ostream_msg, e);
        end
      end
      rx_count++;
    end
  end

  task automatic send(input logic [31:0] n, input logic [31:0] x, input logic [31:0] e);
    int unsigned waited = 0;
    istream_msg = {n, x};
    istream_val = 1'b1;
    while (istream_rdy !== 1'b1 && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (istream_rdy !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout got=%b expected=1", istream_rdy);
      istream_val = 1'b0;
      return;
    end
    accept_rx = rx_count;
    sb.push_back(e);
    @(posedge clk); #1;
    istream_val = 1'b0;
  endtask

  task automatic wait_val(output int unsigned lat);
    lat = 1;
    while (ostream_val !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic wait_drain();
    int unsigned waited = 0;
    while (sb.size() != 0 && waited < 300) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d pending expected=0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0 || ostream_msg !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got=rdy%b val%b msg%0d expected=rdy1 val0 msg0",
               istream_rdy, ostream_val, ostream_msg);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int unsigned lat;
    ostream_rdy = 1'b1;
    send(32'd13, 32'd9, 32'd1);
    wait_val(lat);
    checks++;
    if (lat != 34) begin
      failures++;
      $display("FAIL basic_latency got=%0d expected=34", lat);
    end
    checks++;
    if (ostream_msg !== 32'd1) begin
      failures++;
      $display("FAIL basic_msg got=%0d expected=1", ostream_msg);
    end
    @(posedge clk); #1;
    checks++;
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
      failures++;
      $display("FAIL basic_return_idle got=rdy%b val%b expected=rdy1 val0", istream_rdy, ostream_val);
    end
    wait_drain();
  endtask

  task automatic test_scaled();
    ostream_rdy = 1'b1;
    send(32'd13, 32'd5, 32'd2);
    wait_drain();
    send(32'd13, 32'd0, 32'd0);
    wait_drain();
  endtask

  task automatic test_large_prime();
    ostream_rdy = 1'b1;
    send(32'hFFFFFFFB, 32'd5, 32'd1);
    wait_drain();
    send(32'hFFFFFFFB, 32'd10, 32'd2);
    wait_drain();
  endtask

  task automatic test_backpressure();
    int unsigned lat;
    int unsigned rx0;
    ostream_rdy = 1'b0;
    send(32'd13, 32'd9, 32'd1);
    wait_val(lat);
    rx0 = rx_count;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ostream_val !== 1'b1 || ostream_msg !== 32'd1 || istream_rdy !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=val%b msg%0d rdy%b expected=val1 msg1 rdy0",
                 i, ostream_val, ostream_msg, istream_rdy);
      end
      @(posedge clk); #1;
    end
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rx_count != rx0 + 1 || ostream_val !== 1'b0 || istream_rdy !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got=xfers%0d val%b rdy%b expected=xfers%0d val0 rdy1",
               rx_count - rx0, ostream_val, istream_rdy, 1);
    end
  endtask

  task automatic test_stalls();
    int unsigned first_rx;
    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
        failures++;
        $display("FAIL stall_idle cyc=%0d got=rdy%b val%b expected=rdy1 val0", i, istream_rdy, ostream_val);
      end
    end
    send(32'd13, 32'd9, 32'd1);
    first_rx = rx_count;
    send(32'd13, 32'd5, 32'd2);
    checks++;
    if (accept_rx != first_rx + 1) begin
      failures++;
      $display("FAIL b2b_order got=%0d prior_xfers expected=%0d", accept_rx - first_rx, 1);
    end
    wait_drain();
  endtask

  task automatic test_random();
    logic [31:0] n;
    logic [31:0] x;
    ostream_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = $urandom() | 32'h8000_0001;
      x = $urandom() % n;
      send(n, x, model(n, x));
      wait_drain();
    end
  endtask

  task automatic test_reset_mid();
    int unsigned lat;
    ostream_rdy = 1'b1;
    send(32'd13, 32'd9, 32'd1);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    checks++;
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0 || ostream_msg !== 32'd0) begin
      failures++;
      $display("FAIL midreset_state got=rdy%b val%b msg%0d expected=rdy1 val0 msg0",
               istream_rdy, ostream_val, ostream_msg);
    end
    send(32'd13, 32'd9, 32'd1);
    wait_val(lat);
    checks++;
    if (lat != 34) begin
      failures++;
      $display("FAIL midreset_latency got=%0d expected=34", lat);
    end
    wait_drain();
  endtask

  initial begin
    reset       = 1'b0;
    istream_msg = '0;
    istream_val = 1'b0;
    ostream_rdy = 1'b0;
    test_reset();
    test_basic();
    test_scaled();
    test_large_prime();
    test_backpressure();
    test_stalls();
    test_random();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mont_mod_exp_conv_out.md
Name: mont_mod_exp_conv_out

Overview:
- Output stage of the Montgomery modular-exponentiation accelerator.
- Sits directly downstream of the Montgomery exponentiation multiply stage and consumes its {n, result_mont} message.
- Converts the result out of Montgomery form: result = result_mont * R^-1 mod n, with R = 2^NBITS.
- Uses a bit-serial Montgomery reduction (REDC with multiplicand 1), one bit per cycle, then one final conditional subtract.

Parameters:
- NBITS, 32: operand width; R = 2^NBITS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- istream_msg  input  2*NBITS  {n[63:32], x_mont[31:0]}; layout identical to the upstream stage's output message.
- istream_val  input  1  input message valid.
- istream_rdy  output  1  stage can accept an input message.
- ostream_msg  output  NBITS  converted result.
- ostream_val  output  1  result valid.
- ostream_rdy  input  1  consumer ready.

Behaviour:
- Handshakes: a transfer occurs on a cycle where val && rdy. Standard latency-insensitive val/rdy rules apply:
  - ostream_msg is held stable while ostream_val=1 and ostream_rdy=0.
  - ostream_val never drops without a transfer, except on reset.
- Registers:
  - t: NBITS+1 bits, working value.
  - n_reg: NBITS bits.
  - cnt: 0..NBITS-1, 5 bits for NBITS=32.
  - state: 2 bits.
- Reset (reset==0 at a clock edge):
  - state=IDLE, cnt=0, t=0, n_reg=0.
  - Outputs then read istream_rdy=1, ostream_val=0, ostream_msg=0.
  - Reset has priority over every other event, including a reset asserted mid-CALC or mid-DONE; any in-flight result is discarded.
- IDLE:
  - istream_rdy=1, ostream_val=0.
  - On an input transfer: t <= {1'b0, x_mont}, n_reg <= n, cnt <= 0, go to CALC.
  - No transfer: hold state.
- CALC:
  - istream_rdy=0, ostream_val=0.
  - Each cycle: if t[0]==1 then t <= (t + n_reg) >> 1, else t <= t >> 1.
  - The sum uses an NBITS+1-bit adder; the carry is kept before the shift.
  - cnt increments; after the cycle with cnt==NBITS-1, go to FIX. CALC lasts exactly NBITS cycles.
- FIX (one cycle):
  - if t >= n_reg then t <= t - n_reg, else t unchanged.
  - Go to DONE.
  - One subtract suffices because x_mont < R implies t <= n_reg after CALC.
- DONE:
  - ostream_val=1, ostream_msg=t[NBITS-1:0], istream_rdy=0.
  - On an output transfer, go to IDLE; otherwise hold all registers.
- Latency and throughput:
  - Input accepted in cycle k; ostream_val first high in cycle k+NBITS+2 (k+34 for NBITS=32).
  - Next istream_rdy no earlier than the cycle after the output transfer.
  - Throughput at most 1 result per NBITS+3 cycles.
- Operand rules:
  - n must be odd and nonzero, and x_mont < n for a mathematically meaningful result.
  - If n is even or zero, or x_mont >= n, the stage still completes with identical latency and never hangs; ostream_msg is then whatever the datapath produces.
  - x_mont = 0 always yields 0.
- No combinational path from istream_val to istream_rdy, or from ostream_rdy to ostream_val.

Test Plan:
- Basic, n=13 (R mod 13 = 9): send msg={32'd13, 32'd9}, ostream_rdy=1.
  - Required: ostream_val rises exactly 34 cycles after acceptance, ostream_msg=1; istream_rdy=1 again the cycle after the transfer.
- Scaled value: send {13, 5} (5 = 2·R mod 13).
  - Required: output 2.
  - Then send {13, 0}: required output 0.
- Large prime n=32'hFFFFFFFB (R mod n = 5): send {32'hFFFFFFFB, 32'd5}.
  - Required: output 1, which exercises the 33-bit carry path.
  - Then send {32'hFFFFFFFB, 32'd10}: required output 2.
- Backpressure: send {13, 9} with ostream_rdy=0 for 10 cycles after ostream_val rises.
  - Required: ostream_val stays 1, ostream_msg stays 1, istream_rdy stays 0.
  - On raising ostream_rdy: exactly one transfer, then IDLE.
- Input stalls: hold istream_val=0 for 5 cycles with reset deasserted.
  - Required: istream_rdy=1 and ostream_val=0 throughout, no state change.
  - Then present two messages back-to-back: second accepted only after the first output transfers; results returned in order.
- Reset mid-operation: drive reset=0 for 1 cycle 10 cycles into CALC.
  - Required next cycle: istream_rdy=1, ostream_val=0, ostream_msg=0.
  - A fresh {13, 9} afterwards returns 1 with the 34-cycle latency.
